// File: rtl/ff_pkg.sv
// Shared constants for the universal flip-flop bank: mode encodings and the
// policy applied to an SR cell driven with S=R=1.
package ff_pkg;

    localparam logic [1:0] FF_MODE_D  = 2'd0;
    localparam logic [1:0] FF_MODE_T  = 2'd1;
    localparam logic [1:0] FF_MODE_SR = 2'd2;
    localparam logic [1:0] FF_MODE_JK = 2'd3;

    localparam int SR_INV_HOLD = 0;
    localparam int SR_INV_SET  = 1;
    localparam int SR_INV_CLR  = 2;
    localparam int SR_INV_TOG  = 3;

endpackage

// File: rtl/universal_ff_bank_if.sv
// Control/data bundle of the flip-flop bank. master drives inputs, slave is the bank.
interface universal_ff_bank_if #(
    parameter int WIDTH = 4
) ();
    logic [1:0]       mode;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] sr_err_mask;
    logic             sr_err;

    modport master (
        output mode, en, a, b, load, load_val, clr_err,
        input  q, qb, changed, sr_err_mask, sr_err
    );

    modport slave (
        input  mode, en, a, b, load, load_val, clr_err,
        output q, qb, changed, sr_err_mask, sr_err
    );
endinterface

// File: rtl/ff_next_cell.sv
// Single-bit next-state logic for a D/T/SR/JK flip-flop, plus the SR
// invalid-input (S=R=1) indication. Purely combinational.
module ff_next_cell
    import ff_pkg::*;
#(
    parameter int SR_INV_POLICY = SR_INV_HOLD
) (
    input  logic [1:0] mode,
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic       q_next,
    output logic       sr_inv
);

    logic inv_next;
    logic s_jk;
    logic r_jk;

    // Next value chosen when SR sees S=R=1.
    always_comb begin
        case (SR_INV_POLICY)
            SR_INV_SET: inv_next = 1'b1;
            SR_INV_CLR: inv_next = 1'b0;
            SR_INV_TOG: inv_next = ~q;
            default:    inv_next = q;
        endcase
    end

    // JK expressed as SR with S=J&~q, R=K&q, so J=K=1 toggles and never collides.
    assign s_jk = a & ~q;
    assign r_jk = b & q;

    // Mode-dependent next state; a disabled bit holds and never flags.
    always_comb begin
        q_next = q;
        sr_inv = 1'b0;
        if (en) begin
            case (mode)
                FF_MODE_D: q_next = a;
                FF_MODE_T: q_next = q ^ a;
                FF_MODE_SR: begin
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11: begin
                            q_next = inv_next;
                            sr_inv = 1'b1;
                        end
                        default: q_next = q;
                    endcase
                end
                default:   q_next = s_jk | (q & ~r_jk);
            endcase
        end
    end

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of run-time selectable flip-flops with parallel load,
// per-bit enable, one-cycle change pulses and sticky SR-collision flags.
module universal_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               SR_INV_POLICY = SR_INV_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_ff_bank_if.slave   bus
);

    logic [WIDTH-1:0] q_q,   q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] sr_inv;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_next_cell #(
            .SR_INV_POLICY (SR_INV_POLICY)
        ) u_cell (
            .mode   (bus.mode),
            .q      (q_q[i]),
            .a      (bus.a[i]),
            .b      (bus.b[i]),
            .en     (bus.en[i]),
            .q_next (q_nxt[i]),
            .sr_inv (sr_inv[i])
        );
    end

    // Load overrides the per-bit update; collisions are ignored on load edges,
    // and a fresh collision beats a simultaneous clear.
    always_comb begin
        q_d   = bus.load ? bus.load_val : q_nxt;
        chg_d = q_d ^ q_q;
        err_d = (bus.clr_err ? '0 : err_q) | (bus.load ? '0 : sr_inv);
    end

    // State, change pulses and error mask, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RESET_VAL;
            chg_q <= '0;
            err_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.qb          = ~q_q;
    assign bus.changed     = chg_q;
    assign bus.sr_err_mask = err_q;
    assign bus.sr_err      = |err_q;

endmodule
